// File: rtl/fwd_bypass_network.sv
// Operand forwarding network: tracks DEPTH in-flight writeback stages past EX and
// forwards the youngest matching result to each source operand, flagging load-use hazards.

module fwd_src_sel #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int DEPTH  = 2,
   parameter int SEL_W  = 2
) (
   input  logic [REG_AW-1:0]             src_addr,
   input  logic [DATA_W-1:0]             rf_data,
   input  logic [DEPTH-1:0]              vld,
   input  logic [DEPTH-1:0][REG_AW-1:0]  rd,
   input  logic [DEPTH-1:0][DATA_W-1:0]  data,
   input  logic                          ld0,
   output logic [DATA_W-1:0]             fwd_data,
   output logic [SEL_W-1:0]              fwd_sel,
   output logic                          load_use
);

   // Scan oldest to youngest so the youngest match is the last one to take effect.
   always_comb begin
      fwd_data = rf_data;
      fwd_sel  = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (vld[k] && rd[k] == src_addr && src_addr != '0) begin
            fwd_data = data[k];
            fwd_sel  = SEL_W'(k + 1);
         end
      end
   end

   assign load_use = (fwd_sel == SEL_W'(1)) && ld0;

endmodule

module fwd_bypass_network #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2,
   localparam int SEL_W  = $clog2(DEPTH + 1)
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        Stall_In,
   input  logic                        Flush,
   input  logic [NUM_SRC*REG_AW-1:0]   Src_Addr,
   input  logic [NUM_SRC*DATA_W-1:0]   Src_RF_Data,
   input  logic                        EX_Wr_En,
   input  logic [REG_AW-1:0]           EX_Rd,
   input  logic [DATA_W-1:0]           EX_Result,
   input  logic                        EX_Is_Load,
   input  logic [DATA_W-1:0]           MEM_Load_Data,
   output logic [NUM_SRC*DATA_W-1:0]   Fwd_Data,
   output logic [NUM_SRC*SEL_W-1:0]    Fwd_Sel,
   output logic                        Load_Use_Stall,
   output logic [31:0]                 Stall_Count
);

   logic [DEPTH-1:0]              vld_pipe;
   logic [DEPTH-1:0][REG_AW-1:0]  rd_pipe;
   logic [DEPTH-1:0][DATA_W-1:0]  data_pipe;
   logic                          ld0;
   logic [NUM_SRC-1:0]            lu_vec;
   logic [31:0]                   stall_cnt;

   // Only stage 0 can hold a pending load: load data is merged on the way into stage 1.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vld_pipe  <= '0;
         rd_pipe   <= '0;
         data_pipe <= '0;
         ld0       <= 1'b0;
      end else if (Flush) begin
         vld_pipe  <= '0;
      end else if (!Stall_In) begin
         vld_pipe[0]  <= EX_Wr_En && EX_Rd != '0;
         rd_pipe[0]   <= EX_Rd;
         data_pipe[0] <= EX_Result;
         ld0          <= EX_Is_Load;
         vld_pipe[1]  <= vld_pipe[0];
         rd_pipe[1]   <= rd_pipe[0];
         data_pipe[1] <= ld0 ? MEM_Load_Data : data_pipe[0];
         for (int k = 2; k < DEPTH; k++) begin
            vld_pipe[k]  <= vld_pipe[k-1];
            rd_pipe[k]   <= rd_pipe[k-1];
            data_pipe[k] <= data_pipe[k-1];
         end
      end
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_sel #(
         .DATA_W (DATA_W),
         .REG_AW (REG_AW),
         .DEPTH  (DEPTH),
         .SEL_W  (SEL_W)
      ) u_sel (
         .src_addr (Src_Addr[i*REG_AW +: REG_AW]),
         .rf_data  (Src_RF_Data[i*DATA_W +: DATA_W]),
         .vld      (vld_pipe),
         .rd       (rd_pipe),
         .data     (data_pipe),
         .ld0      (ld0),
         .fwd_data (Fwd_Data[i*DATA_W +: DATA_W]),
         .fwd_sel  (Fwd_Sel[i*SEL_W +: SEL_W]),
         .load_use (lu_vec[i])
      );
   end

   assign Load_Use_Stall = |lu_vec;

   always_ff @(posedge Clk) begin
      if (Reset)
         stall_cnt <= '0;
      else if (Load_Use_Stall && stall_cnt != 32'hFFFF_FFFF)
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign Stall_Count = stall_cnt;

endmodule

// File: tb/tb_fwd_bypass_network.sv
// Bench for fwd_bypass_network: directed vector table, hand sequences for stall/flush/
// saturation/reset, then random traffic against a queue-based reference model.

module tb_fwd_bypass_network;

   logic        Clk = 1'b0;
   logic        Reset, Stall_In, Flush;
   logic [9:0]  Src_Addr;
   logic [63:0] Src_RF_Data;
   logic        EX_Wr_En;
   logic [4:0]  EX_Rd;
   logic [31:0] EX_Result;
   logic        EX_Is_Load;
   logic [31:0] MEM_Load_Data;
   logic [63:0] Fwd_Data;
   logic [3:0]  Fwd_Sel;
   logic        Load_Use_Stall;
   logic [31:0] Stall_Count;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   fwd_bypass_network dut (
      .Clk(Clk), .Reset(Reset), .Stall_In(Stall_In), .Flush(Flush),
      .Src_Addr(Src_Addr), .Src_RF_Data(Src_RF_Data),
      .EX_Wr_En(EX_Wr_En), .EX_Rd(EX_Rd), .EX_Result(EX_Result), .EX_Is_Load(EX_Is_Load),
      .MEM_Load_Data(MEM_Load_Data), .Fwd_Data(Fwd_Data), .Fwd_Sel(Fwd_Sel),
      .Load_Use_Stall(Load_Use_Stall), .Stall_Count(Stall_Count)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_ex(input logic wr, input logic [4:0] rd, input logic [31:0] res, input logic ld);
      EX_Wr_En = wr; EX_Rd = rd; EX_Result = res; EX_Is_Load = ld;
   endtask

   task automatic set_src(input logic [4:0] a0, input logic [31:0] r0, input logic [4:0] a1, input logic [31:0] r1);
      Src_Addr = {a1, a0}; Src_RF_Data = {r1, r0};
   endtask

   typedef struct {
      logic        wr;  logic [4:0] rd;  logic [31:0] res; logic ld; logic [31:0] mem;
      logic [4:0]  a0;  logic [31:0] r0; logic [4:0] a1;   logic [31:0] r1;
      logic [1:0]  es0; logic [31:0] ed0; logic ck_d0;
      logic [1:0]  es1; logic [31:0] ed1;
      logic        est; logic [31:0] ecnt;
   } vec_t;

   vec_t vec [8];

   // Reference model: a queue of in-flight entries, index 0 = youngest.
   typedef struct { logic v; logic [4:0] rd; logic [31:0] d; logic ld; } ent_t;
   ent_t        mq[$];
   logic [63:0] mcnt;

   task automatic model_reset();
      ent_t e;
      e = '{1'b0, 5'd0, 32'd0, 1'b0};
      mq.delete();
      for (int k = 0; k < 2; k++) mq.push_back(e);
      mcnt = 0;
   endtask

   task automatic model_eval(input logic [4:0] a, input logic [31:0] rf,
                             output logic [1:0] sel, output logic [31:0] d, output logic lu);
      sel = 0; d = rf; lu = 0;
      if (a != 0) begin
         for (int k = 0; k < mq.size(); k++) begin
            if (sel == 0 && mq[k].v && mq[k].rd == a) begin
               sel = 2'(k + 1); d = mq[k].d;
            end
         end
      end
      lu = (sel == 2'd1) && mq[0].ld;
   endtask

   task automatic model_step(input logic stall_now);
      ent_t e, n;
      if (Reset) begin
         model_reset();
         return;
      end
      if (stall_now) mcnt = (mcnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mcnt + 1;
      if (Flush) begin
         foreach (mq[k]) mq[k].v = 1'b0;
      end else if (!Stall_In) begin
         e = mq[0];
         if (e.ld) e.d = MEM_Load_Data;
         e.ld = 1'b0;
         mq[0] = e;
         n = '{EX_Wr_En && EX_Rd != 0, EX_Rd, EX_Result, EX_Is_Load};
         mq.push_front(n);
         void'(mq.pop_back());
      end
   endtask

   initial begin
      logic [1:0]  s0, s1;
      logic [31:0] d0, d1;
      logic        l0, l1;

      Reset = 1'b1; Stall_In = 1'b0; Flush = 1'b0; MEM_Load_Data = '0;
      set_ex(0, 0, 0, 0);
      set_src(5'd3, 32'h22, 5'd5, 32'h11);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_sel", 64'(Fwd_Sel), 0);
      chk("rst_data", Fwd_Data, {32'h11, 32'h22});
      chk("rst_stall", 64'(Load_Use_Stall), 0);
      chk("rst_cnt", 64'(Stall_Count), 0);
      Reset = 1'b0;

      //        wr rd     res          ld mem          a0    r0      a1    r1      es0 ed0        ck es1 ed1     est ecnt
      vec[0] = '{1, 5'd3, 32'hAAAA,    0, 32'h0,       5'd3, 32'h22, 5'd5, 32'h11, 0, 32'h22,   1, 0, 32'h11, 0, 0};
      vec[1] = '{0, 5'd0, 32'h0,       0, 32'h0,       5'd3, 32'h22, 5'd5, 32'h11, 1, 32'hAAAA, 1, 0, 32'h11, 0, 0};
      vec[2] = '{1, 5'd3, 32'h1,       0, 32'h0,       5'd3, 32'h22, 5'd5, 32'h11, 2, 32'hAAAA, 1, 0, 32'h11, 0, 0};
      vec[3] = '{1, 5'd3, 32'h2,       0, 32'h0,       5'd3, 32'h22, 5'd5, 32'h11, 1, 32'h1,    1, 0, 32'h11, 0, 0};
      vec[4] = '{1, 5'd0, 32'h99,      0, 32'h0,       5'd3, 32'h22, 5'd5, 32'h11, 1, 32'h2,    1, 0, 32'h11, 0, 0};
      vec[5] = '{1, 5'd7, 32'h100,     1, 32'h0,       5'd0, 32'h33, 5'd3, 32'h11, 0, 32'h33,   1, 2, 32'h2,  0, 0};
      vec[6] = '{0, 5'd0, 32'h0,       0, 32'hBEEF,    5'd7, 32'h22, 5'd5, 32'h11, 1, 32'h0,    0, 0, 32'h11, 1, 0};
      vec[7] = '{0, 5'd0, 32'h0,       0, 32'h0,       5'd7, 32'h22, 5'd0, 32'h11, 2, 32'hBEEF, 1, 0, 32'h11, 0, 1};

      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         set_ex(vec[i].wr, vec[i].rd, vec[i].res, vec[i].ld);
         MEM_Load_Data = vec[i].mem;
         set_src(vec[i].a0, vec[i].r0, vec[i].a1, vec[i].r1);
         #1;
         chk($sformatf("v%0d_sel0", i), 64'(Fwd_Sel[1:0]), 64'(vec[i].es0));
         if (vec[i].ck_d0) chk($sformatf("v%0d_d0", i), 64'(Fwd_Data[31:0]), 64'(vec[i].ed0));
         chk($sformatf("v%0d_sel1", i), 64'(Fwd_Sel[3:2]), 64'(vec[i].es1));
         chk($sformatf("v%0d_d1", i), 64'(Fwd_Data[63:32]), 64'(vec[i].ed1));
         chk($sformatf("v%0d_stall", i), 64'(Load_Use_Stall), 64'(vec[i].est));
         chk($sformatf("v%0d_cnt", i), 64'(Stall_Count), 64'(vec[i].ecnt));
      end

      // Stall_In holds the chain; EX writes during the hold are ignored.
      @(negedge Clk);
      set_ex(1, 5'd4, 32'h55, 0);
      set_src(5'd4, 32'h44, 5'd0, 32'h11);
      @(negedge Clk);
      Stall_In = 1'b1;
      set_ex(1, 5'd4, 32'h66, 0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("hold%0d_sel", c), 64'(Fwd_Sel[1:0]), 1);
         chk($sformatf("hold%0d_data", c), 64'(Fwd_Data[31:0]), 32'h55);
         @(negedge Clk);
      end
      Flush = 1'b1;
      @(negedge Clk);
      Flush = 1'b0; Stall_In = 1'b0;
      set_ex(0, 0, 0, 0);
      #1;
      chk("flush_sel", 64'(Fwd_Sel[1:0]), 0);
      chk("flush_data", 64'(Fwd_Data[31:0]), 32'h44);

      // Saturation: hold a load in stage 0 under Stall_In with a dependent operand.
      @(negedge Clk);
      set_ex(1, 5'd9, 32'h200, 1);
      set_src(5'd0, 32'h0, 5'd0, 32'h0);
      @(negedge Clk);
      Stall_In = 1'b1;
      set_ex(0, 0, 0, 0);
      set_src(5'd9, 32'h0, 5'd0, 32'h0);
      force dut.stall_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt;
      chk("sat_pre", 64'(Stall_Count), 32'hFFFF_FFFE);
      chk("sat_stall", 64'(Load_Use_Stall), 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         #1;
         chk($sformatf("sat%0d_cnt", c), 64'(Stall_Count), 32'hFFFF_FFFF);
      end
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0; Stall_In = 1'b0;
      #1;
      chk("rst2_cnt", 64'(Stall_Count), 0);
      chk("rst2_stall", 64'(Load_Use_Stall), 0);
      chk("rst2_sel", 64'(Fwd_Sel), 0);

      // Random traffic against the reference model.
      model_reset();
      for (int c = 0; c < 600; c++) begin
         @(negedge Clk);
         Reset    = ($urandom_range(0, 99) < 2);
         Stall_In = ($urandom_range(0, 99) < 20);
         Flush    = ($urandom_range(0, 99) < 5);
         set_ex($urandom_range(0, 99) < 70, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 99) < 30);
         MEM_Load_Data = $urandom;
         set_src(5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom);
         #1;
         model_eval(Src_Addr[4:0], Src_RF_Data[31:0], s0, d0, l0);
         model_eval(Src_Addr[9:5], Src_RF_Data[63:32], s1, d1, l1);
         chk("rnd_sel0", 64'(Fwd_Sel[1:0]), 64'(s0));
         chk("rnd_sel1", 64'(Fwd_Sel[3:2]), 64'(s1));
         if (!l0) chk("rnd_d0", 64'(Fwd_Data[31:0]), 64'(d0));
         if (!l1) chk("rnd_d1", 64'(Fwd_Data[63:32]), 64'(d1));
         chk("rnd_stall", 64'(Load_Use_Stall), 64'(l0 | l1));
         chk("rnd_cnt", 64'(Stall_Count), mcnt);
         model_step(l0 | l1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
